keypad_entry_reg: RTL and testbench

//   Upstream stage of the timer counter chain. Collects debounced keypad

---
 rtl/keypad_entry_reg.sv | 162 ++++++++++++++++
 tb/tb_keypad_entry_reg.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_reg.sv
// rtl/keypad_entry_reg.sv - microwave-style keypad digit entry feeding the timer counter loads
module keypad_entry_reg #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       clearn,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       start,
   input  logic       clear,
   input  logic       running,
   output logic [3:0] data_mins,
   output logic [3:0] data_sec_tens,
   output logic [3:0] data_sec_ones,
   output logic       loadn,
   output logic [1:0] digit_count,
   output logic       entry_err
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   state_t          state;
   logic            sync1;
   logic            sync2;
   logic            level;
   logic            armed;
   logic [CW-1:0]   run_cnt;
   logic [CW-1:0]   run_cnt_next;
   logic            level_reach;
   logic            hit_high;
   logic            hit_low;
   logic            accept;
   logic            digit_ok;
   logic [3:0]      sh_mins;
   logic [3:0]      sh_tens;
   logic [3:0]      sh_ones;
   logic [1:0]      sh_cnt;

   // Two-flop synchronizer for the asynchronous key level
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= key_valid;
         sync2 <= sync1;
      end
   end

   // Next run length of the synchronized level; reach fires once per run
   always_comb begin
      run_cnt_next = run_cnt;
      if (sync2 != level) begin
         run_cnt_next = CW'(1);
      end else if (run_cnt != CNT_MAX) begin
         run_cnt_next = run_cnt + CW'(1);
      end
      level_reach = (run_cnt_next == CNT_MAX) && ((sync2 != level) || (run_cnt != CNT_MAX));
   end

   assign hit_high = level_reach & sync2;
   assign hit_low  = level_reach & ~sync2;
   assign accept   = hit_high & armed;
   assign digit_ok = accept && (key_code <= 4'd9) && !running && (state != S_LOAD);

   // Debounce run counter and re-arm flag: one accept per stable press
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         level   <= 1'b0;
         run_cnt <= '0;
         armed   <= 1'b0;
      end else begin
         level   <= sync2;
         run_cnt <= run_cnt_next;
         if (hit_high) begin
            armed <= 1'b0;
         end else if (hit_low) begin
            armed <= 1'b1;
         end
      end
   end

   // Entry register after an accepted digit shifts in; oldest minute digit falls off
   always_comb begin
      sh_mins = data_mins;
      sh_tens = data_sec_tens;
      sh_ones = data_sec_ones;
      sh_cnt  = digit_count;
      if (digit_ok) begin
         sh_mins = data_sec_tens;
         sh_tens = data_sec_ones;
         sh_ones = key_code;
         if (digit_count != 2'd3) begin
            sh_cnt = digit_count + 2'd1;
         end
      end
   end

   // Entry FSM with registered digits, load strobe and error pulse
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         state         <= S_IDLE;
         data_mins     <= 4'd0;
         data_sec_tens <= 4'd0;
         data_sec_ones <= 4'd0;
         digit_count   <= 2'd0;
         loadn         <= 1'b1;
         entry_err     <= 1'b0;
      end else begin
         entry_err <= 1'b0;
         loadn     <= 1'b1;
         case (state)
            S_LOAD: begin
               data_mins     <= 4'd0;
               data_sec_tens <= 4'd0;
               data_sec_ones <= 4'd0;
               digit_count   <= 2'd0;
               state         <= S_IDLE;
            end
            S_IDLE, S_ENTRY: begin
               if (!running) begin
                  if (clear) begin
                     data_mins     <= 4'd0;
                     data_sec_tens <= 4'd0;
                     data_sec_ones <= 4'd0;
                     digit_count   <= 2'd0;
                     state         <= S_IDLE;
                  end else begin
                     data_mins     <= sh_mins;
                     data_sec_tens <= sh_tens;
                     data_sec_ones <= sh_ones;
                     digit_count   <= sh_cnt;
                     if (digit_ok) begin
                        state <= S_ENTRY;
                     end
                     // A start with nothing entered is a no-op
                     if (start && ((state == S_ENTRY) || digit_ok)) begin
                        if (sh_tens <= 4'd5) begin
                           state <= S_LOAD;
                           loadn <= 1'b0;
                        end else begin
                           entry_err <= 1'b1;
                        end
                     end
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_entry_reg.sv
// tb/tb_keypad_entry_reg.sv - directed bench with behavioural entry model for keypad_entry_reg
module tb_keypad_entry_reg;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       clearn = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       start = 1'b0;
   logic       clear = 1'b0;
   logic       running = 1'b0;
   logic [3:0] data_mins;
   logic [3:0] data_sec_tens;
   logic [3:0] data_sec_ones;
   logic       loadn;
   logic [1:0] digit_count;
   logic       entry_err;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // model state
   int rawq[$];
   int synq[$];
   int q[$];
   bit armed_m = 1'b0;
   bit load_m = 1'b0;
   int m_mins = 0;
   int m_tens = 0;
   int m_ones = 0;
   int m_cnt = 0;
   int m_loadn = 1;
   int m_err = 0;

   keypad_entry_reg #(.DEBOUNCE_CYCLES(N)) dut (
      .clk          (clk),
      .clearn       (clearn),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .start        (start),
      .clear        (clear),
      .running      (running),
      .data_mins    (data_mins),
      .data_sec_tens(data_sec_tens),
      .data_sec_ones(data_sec_ones),
      .loadn        (loadn),
      .digit_count  (digit_count),
      .entry_err    (entry_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit window_edge(input int val);
      int ns;
      ns = synq.size();
      if (ns < N) return 1'b0;
      for (int i = ns - N; i < ns; i++) begin
         if (synq[i] != val) return 1'b0;
      end
      if (ns == N) return 1'b1;
      return synq[ns - N - 1] != val;
   endfunction

   // Behavioural model: the synchronized level seen at edge t is the raw level sampled two edges earlier
   initial begin
      forever begin
         @(posedge clk or negedge clearn);
         if (!clearn) begin
            rawq.delete();
            synq.delete();
            q.delete();
            armed_m = 1'b0;
            load_m  = 1'b0;
            m_loadn = 1;
            m_err   = 0;
         end else begin
            int  syn;
            bit  hi;
            bit  lo;
            bit  acc;
            int  n;
            syn = (rawq.size() >= 2) ? rawq[rawq.size() - 2] : 0;
            rawq.push_back(int'(key_valid));
            if (rawq.size() > 3) void'(rawq.pop_front());
            synq.push_back(syn);
            if (synq.size() > N + 1) void'(synq.pop_front());
            hi  = window_edge(1);
            lo  = window_edge(0);
            acc = hi && armed_m;
            if (hi) armed_m = 1'b0;
            if (lo) armed_m = 1'b1;
            m_err   = 0;
            m_loadn = 1;
            if (load_m) begin
               q.delete();
               load_m = 1'b0;
            end else if (!running) begin
               if (clear) begin
                  q.delete();
               end else begin
                  if (acc && key_code <= 4'd9) begin
                     q.push_back(int'(key_code));
                     if (q.size() > 3) void'(q.pop_front());
                  end
                  n = q.size();
                  if (start && n > 0) begin
                     if (((n >= 2) ? q[n - 2] : 0) <= 5) begin
                        load_m  = 1'b1;
                        m_loadn = 0;
                     end else begin
                        m_err = 1;
                     end
                  end
               end
            end
         end
         m_cnt  = q.size();
         m_ones = (m_cnt >= 1) ? q[m_cnt - 1] : 0;
         m_tens = (m_cnt >= 2) ? q[m_cnt - 2] : 0;
         m_mins = (m_cnt >= 3) ? q[m_cnt - 3] : 0;
      end
   end

   // Compare every output against the model away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmp_mins", int'(data_mins), m_mins);
         check("cmp_tens", int'(data_sec_tens), m_tens);
         check("cmp_ones", int'(data_sec_ones), m_ones);
         check("cmp_count", int'(digit_count), m_cnt);
         check("cmp_loadn", int'(loadn), m_loadn);
         check("cmp_err", int'(entry_err), m_err);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int code, input bit glitch);
      key_code = code[3:0];
      if (glitch) begin
         key_valid = 1'b1; tick();
         key_valid = 1'b0; tick();
      end
      key_valid = 1'b1;
      repeat (10) tick();
      if (glitch) begin
         key_valid = 1'b0; tick();
         key_valid = 1'b1; tick();
      end
      key_valid = 1'b0;
      repeat (10) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      #2 clearn = 1'b0;
      #1 cmp_en = 1'b1;
      repeat (3) tick();
      check("reset_loadn", int'(loadn), 1);
      check("reset_count", int'(digit_count), 0);
      check("reset_ones", int'(data_sec_ones), 0);
      check("reset_err", int'(entry_err), 0);
      clearn = 1'b1;
      repeat (10) tick();

      // 1: bouncy 1,2,3 then start
      press(1, 1'b1);
      check("t1_count_after_1", int'(digit_count), 1);
      press(2, 1'b1);
      press(3, 1'b1);
      check("t1_count", int'(digit_count), 3);
      pulse_start();
      check("t1_loadn_low", int'(loadn), 0);
      check("t1_mins", int'(data_mins), 1);
      check("t1_tens", int'(data_sec_tens), 2);
      check("t1_ones", int'(data_sec_ones), 3);
      tick();
      check("t1_loadn_high", int'(loadn), 1);
      check("t1_count_cleared", int'(digit_count), 0);
      check("t1_ones_cleared", int'(data_sec_ones), 0);

      // 2: four digits drop the oldest
      press(1, 1'b0);
      press(2, 1'b0);
      press(3, 1'b0);
      press(4, 1'b0);
      check("t2_count", int'(digit_count), 3);
      check("t2_mins", int'(data_mins), 2);
      pulse_start();
      check("t2_loadn_low", int'(loadn), 0);
      check("t2_tens", int'(data_sec_tens), 3);
      check("t2_ones", int'(data_sec_ones), 4);
      tick();

      // 3: 9,0 gives tens=9, start rejected
      press(9, 1'b0);
      press(0, 1'b0);
      pulse_start();
      check("t3_err_pulse", int'(entry_err), 1);
      check("t3_loadn", int'(loadn), 1);
      tick();
      check("t3_err_gone", int'(entry_err), 0);
      check("t3_tens_kept", int'(data_sec_tens), 9);
      check("t3_count_kept", int'(digit_count), 2);
      pulse_clear();
      check("t3_cleared", int'(digit_count), 0);

      // 4: clear and start together
      press(5, 1'b0);
      clear = 1'b1;
      start = 1'b1;
      tick();
      clear = 1'b0;
      start = 1'b0;
      check("t4_loadn", int'(loadn), 1);
      check("t4_err", int'(entry_err), 0);
      check("t4_count", int'(digit_count), 0);
      tick();
      check("t4_loadn_next", int'(loadn), 1);

      // 5: running lock and non-digit code
      running = 1'b1;
      press(7, 1'b0);
      check("t5_running", int'(digit_count), 0);
      running = 1'b0;
      press(12, 1'b0);
      check("t5_code12", int'(digit_count), 0);

      // 6: async reset during LOAD
      press(5, 1'b0);
      pulse_start();
      check("t6_loadn_low", int'(loadn), 0);
      #2 clearn = 1'b0;
      #1;
      check("t6_loadn_async", int'(loadn), 1);
      check("t6_ones_async", int'(data_sec_ones), 0);
      check("t6_count_async", int'(digit_count), 0);
      tick();
      clearn = 1'b1;
      repeat (10) tick();

      // 7: short pulse rejected, long hold accepted once with fixed latency
      key_code  = 4'd8;
      key_valid = 1'b1;
      repeat (N - 1) tick();
      key_valid = 1'b0;
      repeat (10) tick();
      check("t7_short", int'(digit_count), 0);
      key_valid = 1'b1;
      n = 0;
      while (digit_count == 2'd0 && n < 20) begin
         tick();
         n++;
      end
      check("t7_latency", n, 2 + N);
      repeat (100 - n) tick();
      check("t7_hold_once", int'(digit_count), 1);
      check("t7_ones", int'(data_sec_ones), 8);
      key_valid = 1'b0;
      repeat (10) tick();
      pulse_clear();
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
